// File: rtl/battle_board_if.sv
// Host-side bundle for battle_board_ctrl: placement, attack, VGA read port and status.
// The host drives requests (master); the controller answers (slave).
interface battle_board_if #(
  parameter int N         = 5,
  parameter int MAX_SHIPS = 4,
  parameter int LEN_MAX   = 3
);
  localparam int CW = $clog2(N);
  localparam int LW = $clog2(LEN_MAX + 1);
  localparam int SW = $clog2(MAX_SHIPS + 1);
  localparam int RW = $clog2(MAX_SHIPS * LEN_MAX + 1);

  logic          clear;
  logic          place_req;
  logic [CW-1:0] place_row;
  logic [CW-1:0] place_col;
  logic [LW-1:0] place_len;
  logic          place_horiz;
  logic          place_ack;
  logic          place_err;
  logic          start_game;
  logic          fire_req;
  logic [CW-1:0] fire_row;
  logic [CW-1:0] fire_col;
  logic          fire_ack;
  logic [1:0]    fire_result;
  logic [CW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [1:0]    rd_cell;
  logic [SW-1:0] ships_placed;
  logic [RW-1:0] cells_remaining;
  logic          all_sunk;
  logic          busy;
  logic [1:0]    phase;

  modport master (
    output clear, place_req, place_row, place_col, place_len, place_horiz,
           start_game, fire_req, fire_row, fire_col, rd_row, rd_col,
    input  place_ack, place_err, fire_ack, fire_result, rd_cell,
           ships_placed, cells_remaining, all_sunk, busy, phase
  );

  modport slave (
    input  clear, place_req, place_row, place_col, place_len, place_horiz,
           start_game, fire_req, fire_row, fire_col, rd_row, rd_col,
    output place_ack, place_err, fire_ack, fire_result, rd_cell,
           ships_placed, cells_remaining, all_sunk, busy, phase
  );
endinterface

// File: rtl/battle_board_ctrl.sv
// Battleship board controller: ship placement with one-cell-per-cycle overlap scan and
// write-back, then attack resolution until every ship cell is hit.
module battle_board_ctrl #(
  parameter int N         = 5,
  parameter int MAX_SHIPS = 4,
  parameter int LEN_MAX   = 3
) (
  input logic           clk,
  input logic           rst,
  battle_board_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam int LW = $clog2(LEN_MAX + 1);
  localparam int SW = $clog2(MAX_SHIPS + 1);
  localparam int RW = $clog2(MAX_SHIPS * LEN_MAX + 1);

  typedef enum logic [1:0] {
    CELL_WATER = 2'b00, CELL_SHIP = 2'b01, CELL_HIT = 2'b10, CELL_MISS = 2'b11
  } cell_e;

  typedef enum logic [2:0] {S_SETUP, S_CHECK, S_WRITE, S_PLAY, S_DONE} state_e;

  localparam logic [1:0] RES_MISS    = 2'b00;
  localparam logic [1:0] RES_HIT     = 2'b01;
  localparam logic [1:0] RES_REPEAT  = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

  state_e        state_q;
  cell_e         board_q [N][N];
  logic [CW-1:0] row_q, col_q;
  logic [LW-1:0] len_q, idx_q;
  logic          horiz_q;
  logic [SW-1:0] ships_q;
  logic [RW-1:0] remaining_q;
  logic          place_ack_q, place_err_q, fire_ack_q, all_sunk_q;
  logic [1:0]    fire_result_q;
  logic [1:0]    rd_cell_q;

  int            place_end;
  logic          place_bad;
  logic          fire_in_range, rd_in_range, scan_last;
  logic [CW-1:0] scan_row, scan_col;

  // An origin off the board on either axis is refused as well, so the scan never leaves the array.
  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    place_end = (bus.place_horiz ? int'(bus.place_col) : int'(bus.place_row))
                + int'(bus.place_len) - 1;
    place_bad = (bus.place_len == '0) || (int'(bus.place_len) > LEN_MAX) ||
                (int'(ships_q) >= MAX_SHIPS) || (int'(bus.place_row) >= N) ||
                (int'(bus.place_col) >= N) || (place_end >= N);
  end

  assign fire_in_range = (int'(bus.fire_row) < N) && (int'(bus.fire_col) < N);
  assign rd_in_range   = (int'(bus.rd_row) < N) && (int'(bus.rd_col) < N);
  assign scan_row      = horiz_q ? row_q : row_q + CW'(idx_q);
  assign scan_col      = horiz_q ? col_q + CW'(idx_q) : col_q;
  assign scan_last     = (idx_q == len_q - LW'(1));

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_SETUP;
      row_q         <= '0;
      col_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      horiz_q       <= 1'b0;
      ships_q       <= '0;
      remaining_q   <= '0;
      place_ack_q   <= 1'b0;
      place_err_q   <= 1'b0;
      fire_ack_q    <= 1'b0;
      fire_result_q <= RES_MISS;
      all_sunk_q    <= 1'b0;
      rd_cell_q     <= CELL_WATER;
      // NOTE: the board array is reset on purpose; a half-written ship must not survive rst.
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          board_q[r][c] <= CELL_WATER;
    end else begin
      place_ack_q <= 1'b0;
      place_err_q <= 1'b0;
      fire_ack_q  <= 1'b0;
      rd_cell_q   <= rd_in_range ? board_q[bus.rd_row][bus.rd_col] : CELL_WATER;

      if (bus.clear) begin
        state_q       <= S_SETUP;
        idx_q         <= '0;
        ships_q       <= '0;
        remaining_q   <= '0;
        all_sunk_q    <= 1'b0;
        fire_result_q <= RES_MISS;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            board_q[r][c] <= CELL_WATER;
      end else begin
        case (state_q)
          S_SETUP: begin
            if (bus.place_req) begin
              if (place_bad) begin
                place_err_q <= 1'b1;
              end else begin
                row_q   <= bus.place_row;
                col_q   <= bus.place_col;
                len_q   <= bus.place_len;
                horiz_q <= bus.place_horiz;
                idx_q   <= '0;
                state_q <= S_CHECK;
              end
            end else if (bus.start_game && ships_q != '0) begin
              state_q <= S_PLAY;
            end
          end

          S_CHECK: begin
            if (board_q[scan_row][scan_col] != CELL_WATER) begin
              place_err_q <= 1'b1;
              state_q     <= S_SETUP;
            end else if (scan_last) begin
              idx_q   <= '0;
              state_q <= S_WRITE;
            end else begin
              idx_q <= idx_q + LW'(1);
            end
          end

          S_WRITE: begin
            board_q[scan_row][scan_col] <= CELL_SHIP;
            if (scan_last) begin
              place_ack_q <= 1'b1;
              ships_q     <= ships_q + SW'(1);
              remaining_q <= remaining_q + RW'(len_q);
              state_q     <= S_SETUP;
            end else begin
              idx_q <= idx_q + LW'(1);
            end
          end

          S_PLAY: begin
            if (bus.fire_req) begin
              fire_ack_q <= 1'b1;
              if (!fire_in_range) begin
                fire_result_q <= RES_INVALID;
              end else begin
                case (board_q[bus.fire_row][bus.fire_col])
                  CELL_WATER: begin
                    fire_result_q                       <= RES_MISS;
                    board_q[bus.fire_row][bus.fire_col] <= CELL_MISS;
                  end
                  CELL_SHIP: begin
                    fire_result_q                       <= RES_HIT;
                    board_q[bus.fire_row][bus.fire_col] <= CELL_HIT;
                    if (remaining_q != '0) remaining_q <= remaining_q - RW'(1);
                    if (remaining_q == RW'(1)) begin
                      all_sunk_q <= 1'b1;
                      state_q    <= S_DONE;
                    end
                  end
                  default: fire_result_q <= RES_REPEAT;
                endcase
              end
            end
          end

          S_DONE:  ;
          default: state_q <= S_SETUP;
        endcase
      end
    end
  end

  assign bus.place_ack       = place_ack_q;
  assign bus.place_err       = place_err_q;
  assign bus.fire_ack        = fire_ack_q;
  assign bus.fire_result     = fire_result_q;
  assign bus.rd_cell         = rd_cell_q;
  assign bus.ships_placed    = ships_q;
  assign bus.cells_remaining = remaining_q;
  assign bus.all_sunk        = all_sunk_q;
  assign bus.busy            = (state_q == S_CHECK) || (state_q == S_WRITE);
  assign bus.phase           = (state_q == S_SETUP) ? 2'b00 :
                               (state_q == S_PLAY)  ? 2'b10 :
                               (state_q == S_DONE)  ? 2'b11 : 2'b01;
endmodule

// File: tb/tb_battle_board_ctrl.sv
// Bench for battle_board_ctrl: directed scenarios followed by random games, all checked
// against a board-level model that applies the game rules directly.
module tb_battle_board_ctrl;
  localparam int N      = 5;
  localparam int MS     = 4;
  localparam int LM     = 3;
  localparam int BUDGET = 2 * LM + 3;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  int   mb [N][N];
  int   m_ships, m_rem, m_phase;
  int   m_sunk;

  battle_board_if #(.N(N), .MAX_SHIPS(MS), .LEN_MAX(LM)) bus ();

  battle_board_ctrl #(.N(N), .MAX_SHIPS(MS), .LEN_MAX(LM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mb[r][c] = 0;
    m_ships = 0; m_rem = 0; m_phase = 0; m_sunk = 0;
  endtask

  // kind: 0 nothing, 1 ack, 2 err; lat: cycles from request to the pulse.
  task automatic model_place(input int r, c, l, input bit h, output int kind, output int lat);
    kind = 2; lat = 1;
    if (m_phase != 0) begin kind = 0; lat = 0; return; end
    if (l == 0 || l > LM || m_ships >= MS || r >= N || c >= N) return;
    if ((h ? c : r) + l - 1 >= N) return;
    for (int k = 0; k < l; k++)
      if (mb[h ? r : r + k][h ? c + k : c] != 0) begin lat = k + 2; return; end
    for (int k = 0; k < l; k++) mb[h ? r : r + k][h ? c + k : c] = 1;
    m_ships++;
    m_rem += l;
    kind = 1;
    lat  = 2 * l + 1;
  endtask

  task automatic model_fire(input int r, c, output int ack, output int res);
    ack = 0; res = 0;
    if (m_phase != 2) return;
    ack = 1;
    if (r >= N || c >= N) begin res = 3; return; end
    case (mb[r][c])
      0: begin res = 0; mb[r][c] = 3; end
      1: begin
        res = 1; mb[r][c] = 2; m_rem--;
        if (m_rem == 0) begin m_sunk = 1; m_phase = 3; end
      end
      default: res = 2;
    endcase
  endtask

  task automatic check_status(input string tag);
    check({tag, "_phase"}, 32'(bus.phase), m_phase);
    check({tag, "_ships"}, 32'(bus.ships_placed), m_ships);
    check({tag, "_remaining"}, 32'(bus.cells_remaining), m_rem);
    check({tag, "_all_sunk"}, 32'(bus.all_sunk), m_sunk);
  endtask

  task automatic check_board(input string tag);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        bus.rd_row = 3'(r);
        bus.rd_col = 3'(c);
        @(negedge clk);
        check($sformatf("%s_r%0dc%0d", tag, r, c), 32'(bus.rd_cell), mb[r][c]);
      end
    bus.rd_row = 3'(N);
    bus.rd_col = 3'(1);
    @(negedge clk);
    check({tag, "_rd_out_of_range"}, 32'(bus.rd_cell), 0);
  endtask

  task automatic place(input int r, c, l, input bit h, input bit with_start, input string tag);
    int ek, el, gk, gl;
    model_place(r, c, l, h, ek, el);
    bus.place_row   = 3'(r);
    bus.place_col   = 3'(c);
    bus.place_len   = 2'(l);
    bus.place_horiz = h;
    bus.place_req   = 1'b1;
    bus.start_game  = with_start;
    gk = 0; gl = 0;
    for (int t = 1; t <= BUDGET && gk == 0; t++) begin
      @(negedge clk);
      if (t == 1) begin
        bus.place_req  = 1'b0;
        bus.start_game = 1'b0;
        if (with_start) check({tag, "_place_wins"}, 32'(bus.phase), (ek == 1) ? 1 : 0);
      end
      if (bus.place_ack)      begin gk = 1; gl = t; end
      else if (bus.place_err) begin gk = 2; gl = t; end
    end
    check({tag, "_kind"}, gk, ek);
    check({tag, "_latency"}, gl, el);
    check_status(tag);
  endtask

  task automatic fire(input int r, c, input string tag);
    int ea, er;
    model_fire(r, c, ea, er);
    bus.fire_row = 3'(r);
    bus.fire_col = 3'(c);
    bus.fire_req = 1'b1;
    @(negedge clk);
    bus.fire_req = 1'b0;
    check({tag, "_ack"}, 32'(bus.fire_ack), ea);
    if (ea != 0) check({tag, "_result"}, 32'(bus.fire_result), er);
    check_status(tag);
  endtask

  task automatic start(input string tag);
    bus.start_game = 1'b1;
    @(negedge clk);
    bus.start_game = 1'b0;
    if (m_phase == 0 && m_ships > 0) m_phase = 2;
    check_status(tag);
  endtask

  task automatic clear_board(input string tag);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_reset();
    check({tag, "_no_ack"}, 32'(bus.place_ack), 0);
    check_status(tag);
  endtask

  initial begin
    bus.clear = 1'b0; bus.place_req = 1'b0; bus.place_row = '0; bus.place_col = '0;
    bus.place_len = '0; bus.place_horiz = 1'b0; bus.start_game = 1'b0;
    bus.fire_req = 1'b0; bus.fire_row = '0; bus.fire_col = '0;
    bus.rd_row = '0; bus.rd_col = '0;
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_phase", 32'(bus.phase), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ships", 32'(bus.ships_placed), 0);
    check("rst_remaining", 32'(bus.cells_remaining), 0);
    check("rst_all_sunk", 32'(bus.all_sunk), 0);
    check("rst_place_ack", 32'(bus.place_ack), 0);
    check("rst_place_err", 32'(bus.place_err), 0);
    check("rst_fire_ack", 32'(bus.fire_ack), 0);
    check("rst_fire_result", 32'(bus.fire_result), 0);
    check("rst_rd_cell", 32'(bus.rd_cell), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    start("start_no_ships");
    place(1, 1, 3, 1'b1, 1'b0, "place_h3");
    place(0, 2, 2, 1'b0, 1'b0, "place_overlap");
    place(4, 3, 3, 1'b1, 1'b0, "place_bounds");
    check_board("board_one_ship");

    // Clear lands while the second ship is being written.
    bus.place_row = 3'(3); bus.place_col = 3'(0); bus.place_len = 2'(2);
    bus.place_horiz = 1'b1; bus.place_req = 1'b1;
    @(negedge clk);
    bus.place_req = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_write_busy", 32'(bus.busy), 1);
    check("mid_write_phase", 32'(bus.phase), 1);
    clear_board("clear_mid_write");
    check_board("board_after_clear");

    // Asynchronous reset while a ship is half written.
    bus.place_row = 3'(2); bus.place_col = 3'(0); bus.place_len = 2'(3);
    bus.place_horiz = 1'b0; bus.place_req = 1'b1;
    @(negedge clk);
    bus.place_req = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 0);
    check("async_rst_phase", 32'(bus.phase), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    check_board("board_after_rst");

    place(1, 1, 3, 1'b1, 1'b0, "replace_h3");
    place(3, 0, 1, 1'b1, 1'b1, "place_with_start");
    start("start_play");
    place(4, 0, 1, 1'b1, 1'b0, "place_in_play");
    fire(1, 1, "fire_hit");
    fire(1, 1, "fire_repeat");
    fire(0, 0, "fire_miss");
    fire(5, 0, "fire_invalid");
    fire(1, 2, "fire_hit2");
    fire(1, 3, "fire_hit3");
    fire(3, 0, "fire_sink");
    fire(2, 2, "fire_in_done");
    start("start_in_done");
    check_board("board_done");

    for (int g = 0; g < 3; g++) begin
      clear_board("rnd_clear");
      for (int p = 0; p < 8; p++)
        place($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, LM),
              1'($urandom_range(0, 1)), 1'b0, "rnd_place");
      check_board("rnd_board_setup");
      start("rnd_start");
      for (int s = 0; s < 30; s++)
        fire($urandom_range(0, N), $urandom_range(0, N), "rnd_fire");
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          fire(r, c, "rnd_sweep");
      check_board("rnd_board_end");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/battle_board_ctrl.md
BATTLE_BOARD_CTRL -- requirements
Module: battle_board_ctrl

Interface
REQ-001 Parameter N, default 5, board dimension (N x N cells), 2..8.
REQ-002 Parameter MAX_SHIPS, default 4, maximum ships accepted per board.
REQ-003 Parameter LEN_MAX, default 3, maximum ship length, 1..N.
REQ-004 Derived: CW = $clog2(N); LW = $clog2(LEN_MAX+1); SW = $clog2(MAX_SHIPS+1); RW = $clog2(MAX_SHIPS*LEN_MAX+1).
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 clear  input  1  synchronous board clear, priority over all other requests.
REQ-008 place_req  input  1  one-cycle request to place a ship.
REQ-009 place_row, place_col  input  CW each  ship origin cell.
REQ-010 place_len  input  LW  ship length.
REQ-011 place_horiz  input  1  1 = extends along columns (col+k), 0 = along rows (row+k).
REQ-012 place_ack  output  1  one-cycle pulse, placement committed.
REQ-013 place_err  output  1  one-cycle pulse, placement rejected, board unchanged.
REQ-014 start_game  input  1  request to leave setup and enter play.
REQ-015 fire_req, fire_row, fire_col  input  1, CW, CW  attack request and target.
REQ-016 fire_ack  output  1  one-cycle pulse, attack resolved.
REQ-017 fire_result  output  2  00 miss, 01 hit, 10 repeat (cell already attacked), 11 invalid (out of range).
REQ-018 rd_row, rd_col  input  CW each; rd_cell  output  2  registered cell read port for VGA, 1-cycle latency, reads 00 when out of range.
REQ-019 ships_placed  output  SW; cells_remaining  output  RW; all_sunk  output  1; busy  output  1; phase  output  2 (00 SETUP, 01 BUSY, 10 PLAY, 11 DONE).

Function
REQ-020 Cell encoding: 00 water, 01 ship, 10 ship hit, 11 water attacked.
REQ-021 FSM states: SETUP, CHECK, WRITE, PLAY, DONE; phase reports CHECK and WRITE as BUSY; busy = 1 in CHECK and WRITE.
REQ-022 SETUP + place_req: rejected at once (place_err next cycle, stay SETUP) when place_len = 0, place_len > LEN_MAX, ships_placed = MAX_SHIPS, or end cell (origin + len - 1 on the extension axis) >= N; otherwise latch all args and go to CHECK.
REQ-023 CHECK scans one cell per cycle for place_len cycles; any cell != 00 -> place_err pulse, return to SETUP, no cell written.
REQ-024 WRITE writes 01 to one cell per cycle for place_len cycles, then place_ack pulses, ships_placed += 1, cells_remaining += place_len, return to SETUP; request-to-ack latency = 2*place_len + 1 cycles.
REQ-025 place_req, start_game, fire_req while busy are ignored (no ack, no err, no queueing).
REQ-026 SETUP + start_game with ships_placed >= 1 -> PLAY next cycle; with ships_placed = 0 ignored; simultaneous place_req and start_game: place_req wins.
REQ-027 PLAY + fire_req: fire_ack and fire_result on next cycle; 01 -> cell becomes 10, cells_remaining -= 1; 00 -> cell becomes 11, result miss; 10 or 11 -> repeat, no change; coordinate >= N -> invalid, no change.
REQ-028 Hit decrementing cells_remaining from 1 to 0: all_sunk = 1 in the same cycle as fire_ack, FSM enters DONE.
REQ-029 DONE ignores place_req, fire_req, start_game; board frozen; left only via clear or rst.
REQ-030 fire_req outside PLAY and place_req outside SETUP are ignored silently.
REQ-031 clear: next cycle all cells 00, counters 0, all_sunk 0, pending pulses suppressed, FSM to SETUP, including mid-CHECK/WRITE (partial ship discarded).
REQ-032 cells_remaining never underflows; ships_placed saturates at MAX_SHIPS by REQ-022.

Reset
REQ-033 rst low asynchronously: all cells 00, FSM SETUP, ships_placed 0, cells_remaining 0, all_sunk 0, place_ack/place_err/fire_ack 0, fire_result 00, rd_cell 00, busy 0.
REQ-034 rst asserted mid-WRITE leaves no partially written ship after release.

Verification
REQ-035 N=5: place (1,1) len 3 horiz -> place_ack exactly 7 cycles after request; cells (1,1..3) = 01; ships_placed 1; cells_remaining 3.
REQ-036 Overlap: then place (0,2) len 2 vertical -> place_err after CHECK stops at (1,2); board unchanged; bounds case (4,3) len 3 horiz -> place_err next cycle.
REQ-037 start_game with ships_placed 0 -> phase stays 00; after one ship -> phase 10.
REQ-038 PLAY: fire (1,1) -> hit, cell 10; fire (1,1) again -> repeat; fire (0,0) -> miss, cell 11; fire (5,0) -> invalid.
REQ-039 Sink last cell -> all_sunk 1 with fire_ack, phase 11; further fire_req -> no fire_ack.
REQ-040 clear asserted during WRITE of second ship -> next cycle board all 00, counters 0, no place_ack.
